// File: rtl/obi_axil_bridge.sv
// ---------------------------------------------------------------------------
// obi_axil_bridge
//   Converts single data-side OBI accesses from the core into AXI-lite style
//   transactions (aw/w/b for writes, ar/r for reads, no resp fields) towards
//   the peripheral wrapper. One access is in flight at a time. A response
//   timeout converts a hung slave into an OBI error completion so the core
//   never stalls forever.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   data_req_i / data_gnt_o          OBI request / grant (grant only in IDLE)
//   data_addr_i, data_we_i,
//   data_be_i, data_wdata_i          OBI request attributes, latched on grant
//   data_rvalid_o, data_rdata_o,
//   data_err_o                       OBI response, one-cycle pulse
//   m_aw*, m_w*, m_b*                write address / data / response channels
//   m_ar*, m_r*                      read address / data channels
// ---------------------------------------------------------------------------
module obi_axil_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_req_i,
    output logic              data_gnt_o,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_err_o,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              awvalid_q, wvalid_q, arvalid_q;
    logic              bready_q, rready_q;
    logic              rvalid_q, err_q;
    logic [DATA_W-1:0] rdata_q;

    logic aw_fin_s, w_fin_s, counting_s, resp_s, tmo_s;

    // A channel counts as finished once its valid has dropped or it handshakes now.
    assign aw_fin_s   = ~awvalid_q | m_awready;
    assign w_fin_s    = ~wvalid_q  | m_wready;
    assign counting_s = (state_q == S_WR_REQ) | (state_q == S_WR_RESP) |
                        (state_q == S_RD_REQ) | (state_q == S_RD_RESP);
    // Only a slave response completes an access; address handshakes do not.
    assign resp_s     = ((state_q == S_WR_RESP) & m_bvalid) |
                        ((state_q == S_RD_RESP) & m_rvalid);
    assign tmo_s      = counting_s & (cnt_q == CNT_LAST) & ~resp_s;

    assign data_gnt_o    = (state_q == S_IDLE) & data_req_i;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign m_awaddr      = addr_q;
    assign m_araddr      = addr_q;
    assign m_wdata       = wdata_q;
    assign m_wstrb       = be_q;
    assign m_awvalid     = awvalid_q;
    assign m_wvalid      = wvalid_q;
    assign m_arvalid     = arvalid_q;
    assign m_bready      = bready_q;
    assign m_rready      = rready_q;

    // Transaction FSM with registered bus-side and OBI response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            be_q      <= 4'b0000;
            cnt_q     <= {CNT_W{1'b0}};
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b1;
            rready_q  <= 1'b1;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
        end else begin
            rvalid_q <= 1'b0;
            if (counting_s) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (tmo_s) begin
                // Hung slave: abandon the bus side and report an error.
                state_q   <= S_DONE;
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                arvalid_q <= 1'b0;
                bready_q  <= 1'b0;
                rready_q  <= 1'b0;
                rvalid_q  <= 1'b1;
                err_q     <= 1'b1;
                rdata_q   <= ERR_DATA;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (data_req_i) begin
                            addr_q   <= data_addr_i;
                            wdata_q  <= data_wdata_i;
                            be_q     <= data_be_i;
                            cnt_q    <= {CNT_W{1'b0}};
                            bready_q <= 1'b0;
                            rready_q <= 1'b0;
                            if (data_we_i) begin
                                state_q   <= S_WR_REQ;
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                            end else begin
                                state_q   <= S_RD_REQ;
                                arvalid_q <= 1'b1;
                            end
                        end
                    end
                    S_WR_REQ: begin
                        if (m_awready) begin
                            awvalid_q <= 1'b0;
                        end
                        if (m_wready) begin
                            wvalid_q <= 1'b0;
                        end
                        if (aw_fin_s && w_fin_s) begin
                            state_q  <= S_WR_RESP;
                            bready_q <= 1'b1;
                        end
                    end
                    S_WR_RESP: begin
                        if (m_bvalid) begin
                            state_q  <= S_DONE;
                            bready_q <= 1'b0;
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b0;
                            rdata_q  <= {DATA_W{1'b0}};
                        end
                    end
                    S_RD_REQ: begin
                        if (m_arready) begin
                            state_q   <= S_RD_RESP;
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                        end
                    end
                    S_RD_RESP: begin
                        if (m_rvalid) begin
                            state_q  <= S_DONE;
                            rready_q <= 1'b0;
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b0;
                            rdata_q  <= m_rdata;
                        end
                    end
                    S_DONE: begin
                        state_q  <= S_IDLE;
                        bready_q <= 1'b1;
                        rready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obi_axil_bridge.sv
module tb_obi_axil_bridge;

    localparam int          TO       = 16;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
    localparam int          NEVER    = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic [3:0]  data_be_i = 4'h0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic        m_arready = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    obi_axil_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Current scenario: the granted access and the slave's planned timing,
    // expressed as cycle offsets from the grant cycle.
    bit          s_act = 1'b0;
    bit          s_we = 1'b0;
    logic [31:0] s_addr = 32'h0, s_wdata = 32'h0, s_rdat = 32'h0;
    logic [3:0]  s_be = 4'h0;
    int          g_cyc = 0, off_a = 0, off_w = 0, off_r = NEVER;

    int n_cmp = 0, n_bad = 0;
    int obs_rv_k = -1, obs_aw_n = 0, obs_w_n = 0, obs_ar_n = 0;
    logic [31:0] obs_rdata = 32'h0;
    logic        obs_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp_v);
        end
    endtask

    // Offset at which all request-side handshakes have happened.
    function automatic int req_off();
        return (s_we && off_w > off_a) ? off_w : off_a;
    endfunction

    // A response is honoured only after the request phase and within the window.
    function automatic bit resp_ok();
        return (off_r > req_off()) && (off_r <= TO);
    endfunction

    // Offset of the cycle in which the access completes (response or timeout).
    function automatic int done_off();
        return resp_ok() ? off_r : TO;
    endfunction

    // Scripted slave: readies and responses pulse at their planned offsets.
    always @(negedge clk) begin
        int sk;
        #1;
        sk = cyc - g_cyc;
        m_awready = s_act && s_we && (sk == off_a);
        m_wready  = s_act && s_we && (sk == off_w);
        m_bvalid  = s_act && s_we && (sk == off_r);
        m_arready = s_act && !s_we && (sk == off_a);
        m_rvalid  = s_act && !s_we && (sk == off_r);
        m_rdata   = m_rvalid ? s_rdat : 32'hFFFF_FFFF;
    end

    // Per-cycle comparison of the DUT against the transaction-level model.
    always @(negedge clk) begin
        int ck, dn, rq;
        bit in_txn, e_aw, e_w, e_ar, e_rv;
        #2;
        ck = cyc - g_cyc;
        if (data_rvalid_o === 1'b1) begin
            obs_rv_k  = ck;
            obs_rdata = data_rdata_o;
            obs_err   = data_err_o;
        end
        if (!rst_n) begin
            chk("rst_awvalid", m_awvalid, 0);
            chk("rst_wvalid", m_wvalid, 0);
            chk("rst_arvalid", m_arvalid, 0);
            chk("rst_rvalid", data_rvalid_o, 0);
            chk("rst_rdata", data_rdata_o, 0);
            chk("rst_err", data_err_o, 0);
            chk("rst_gnt", data_gnt_o, 0);
        end else begin
            dn     = done_off();
            rq     = req_off();
            in_txn = s_act && ck >= 1 && ck <= dn + 1;
            e_aw   = s_act && s_we && ck >= 1 && ck <= dn && ck <= off_a;
            e_w    = s_act && s_we && ck >= 1 && ck <= dn && ck <= off_w;
            e_ar   = s_act && !s_we && ck >= 1 && ck <= dn && ck <= off_a;
            e_rv   = s_act && ck == dn + 1;
            if (m_awvalid === 1'b1) obs_aw_n++;
            if (m_wvalid === 1'b1) obs_w_n++;
            if (m_arvalid === 1'b1) obs_ar_n++;
            chk("gnt", data_gnt_o, data_req_i && !in_txn);
            chk("awvalid", m_awvalid, e_aw);
            chk("wvalid", m_wvalid, e_w);
            chk("arvalid", m_arvalid, e_ar);
            chk("bready", m_bready, !in_txn || (s_we && ck > rq && ck <= dn));
            chk("rready", m_rready, !in_txn || (!s_we && ck > rq && ck <= dn));
            chk("rvalid", data_rvalid_o, e_rv);
            if (e_aw) chk("awaddr", m_awaddr, s_addr);
            if (e_w) begin
                chk("wdata", m_wdata, s_wdata);
                chk("wstrb", m_wstrb, s_be);
            end
            if (e_ar) chk("araddr", m_araddr, s_addr);
            if (e_rv) begin
                chk("rdata", data_rdata_o, !resp_ok() ? ERR_WORD : (s_we ? 32'h0 : s_rdat));
                chk("err", data_err_o, !resp_ok());
            end
        end
    end

    // Present a request at the current negedge; the DUT is idle so this is the grant cycle.
    task automatic start_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input int oa, input int ow, input int orr,
                             input logic [31:0] rd);
        s_we = we; s_addr = addr; s_wdata = wdata; s_be = be; s_rdat = rd;
        off_a = oa; off_w = ow; off_r = orr; g_cyc = cyc; s_act = 1'b1;
        obs_rv_k = -1; obs_aw_n = 0; obs_w_n = 0; obs_ar_n = 0;
        data_req_i = 1'b1; data_we_i = we; data_addr_i = addr;
        data_wdata_i = wdata; data_be_i = be;
        @(negedge clk);
        // Scramble request fields after grant: the bus must keep the latched copies.
        data_req_i = 1'b0; data_addr_i = ~addr; data_wdata_i = ~wdata; data_be_i = ~be;
    endtask

    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int oa, input int ow, input int orr,
                           input logic [31:0] rd);
        int wait_k;
        start_txn(we, addr, wdata, be, oa, ow, orr, rd);
        wait_k = done_off() + 2;
        if (orr < 100 && orr + 1 > wait_k) wait_k = orr + 1;
        while (cyc - g_cyc < wait_k) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write, always-ready slave, bvalid one cycle after the handshake.
        run_txn(1'b1, 32'h1000_0000, 32'h0000_A5A5, 4'hF, 1, 1, 2, 32'h0);
        chk("t1_rv_cycle", obs_rv_k, 3);
        chk("t1_err", obs_err, 0);
        chk("t1_rdata", obs_rdata, 32'h0);

        // Read with arready delayed by 3 cycles.
        run_txn(1'b0, 32'h1000_1004, 32'h0, 4'hF, 4, 0, 5, 32'h0000_0123);
        chk("t2_ar_cycles", obs_ar_n, 4);
        chk("t2_rv_cycle", obs_rv_k, 6);
        chk("t2_rdata", obs_rdata, 32'h0000_0123);

        // Write with awready early and wready late.
        run_txn(1'b1, 32'h1000_0008, 32'h0000_00FF, 4'h1, 1, 4, 5, 32'h0);
        chk("t3_aw_cycles", obs_aw_n, 1);
        chk("t3_w_cycles", obs_w_n, 4);
        chk("t3_rv_cycle", obs_rv_k, 6);

        // Read timeout; the slave answers late while the bridge is idle.
        run_txn(1'b0, 32'h1000_1000, 32'h0, 4'hF, 1, 0, 20, 32'h0BAD_0BAD);
        chk("t4_rv_cycle", obs_rv_k, 17);
        chk("t4_rdata", obs_rdata, 32'hDEAD_BEEF);
        chk("t4_err", obs_err, 1);
        run_txn(1'b0, 32'h1000_1008, 32'h0, 4'hF, 2, 0, 3, 32'h0000_0777);
        chk("t4_next_rdata", obs_rdata, 32'h0000_0777);
        chk("t4_next_err", obs_err, 0);

        // Response in the last counted cycle completes normally.
        run_txn(1'b0, 32'h1000_1010, 32'h0, 4'hF, 1, 0, 16, 32'h0000_BEEF);
        chk("t5_rv_cycle", obs_rv_k, 17);
        chk("t5_err", obs_err, 0);
        chk("t5_rdata", obs_rdata, 32'h0000_BEEF);

        // Write whose response never arrives.
        run_txn(1'b1, 32'h1000_0004, 32'h1234_5678, 4'hC, 2, 1, NEVER, 32'h0);
        chk("tw_err", obs_err, 1);
        chk("tw_rdata", obs_rdata, 32'hDEAD_BEEF);

        // Reset during WR_RESP aborts without a response.
        start_txn(1'b1, 32'h1000_000C, 32'h0000_5555, 4'hF, 1, 1, NEVER, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        s_act = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_no_resp", obs_rv_k, -1);
        rst_n = 1'b1;
        run_txn(1'b1, 32'h1000_0010, 32'h0000_0042, 4'hF, 1, 1, 2, 32'h0);
        chk("t6_rv_cycle", obs_rv_k, 3);
        chk("t6_err", obs_err, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
